// File: rtl/mux_tree_pkg.sv
// Shared constants for the 7:1 mux tree built from 2:1 cells.
package mux_tree_pkg;

  localparam int N_IN    = 7;  // data lanes
  localparam int N_NODES = 5;  // observable internal tree nodes
  localparam int SEL_W   = 3;  // select width, one bit per tree level

  // Node slots in the packed debug output y.
  localparam int NODE_L1_0 = 0;  // s[0] ? i1 : i0
  localparam int NODE_L1_1 = 1;  // s[0] ? i3 : i2
  localparam int NODE_L1_2 = 2;  // s[0] ? i5 : i4
  localparam int NODE_L2_0 = 3;  // s[1] ? n1 : n0
  localparam int NODE_L2_1 = 4;  // s[1] ? i6 : n2

endpackage

// File: rtl/mux2x1.sv
// Single 2:1 select cell, the only building block of the mux tree.
module mux2x1 #(
  parameter int DW = 1
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sel,
  output logic [DW-1:0] o
);

  // Pure select: b when sel is high, otherwise a.
  always_comb begin
    o = sel ? b : a;
  end

endmodule

// File: rtl/mux7x1_using2x1_dut.sv
// 7:1 mux as a three-level tree of six 2:1 cells, with the five internal
// nodes and the final selection registered for observation.
// Lane 6 bypasses level 1, so s=6 and s=7 both select i6.
module mux7x1_using2x1_dut
  import mux_tree_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*DW-1:0]    i,
  input  logic [SEL_W-1:0]      s,
  output logic [N_NODES*DW-1:0] y,
  output logic [DW-1:0]         Y
);

  logic [DW-1:0]         node [N_NODES];
  logic [DW-1:0]         final_d;
  logic [N_NODES*DW-1:0] nodes_d;
  logic [N_NODES*DW-1:0] nodes_q;
  logic [DW-1:0]         final_q;

  // Level 1: pair up lanes 0..5 under s[0].
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_l1
      mux2x1 #(.DW(DW)) u_cell (
        .a   (i[(2*gi)*DW +: DW]),
        .b   (i[(2*gi+1)*DW +: DW]),
        .sel (s[0]),
        .o   (node[NODE_L1_0+gi])
      );
    end
  endgenerate

  // Level 2: combine the level-1 pairs; lane 6 joins here unmuxed.
  mux2x1 #(.DW(DW)) u_l2_0 (
    .a   (node[NODE_L1_0]),
    .b   (node[NODE_L1_1]),
    .sel (s[1]),
    .o   (node[NODE_L2_0])
  );

  mux2x1 #(.DW(DW)) u_l2_1 (
    .a   (node[NODE_L1_2]),
    .b   (i[6*DW +: DW]),
    .sel (s[1]),
    .o   (node[NODE_L2_1])
  );

  // Level 3: final choice between the lower and upper halves.
  mux2x1 #(.DW(DW)) u_l3 (
    .a   (node[NODE_L2_0]),
    .b   (node[NODE_L2_1]),
    .sel (s[2]),
    .o   (final_d)
  );

  // Pack nodes n0..n4 into the debug vector, n0 in the low slice.
  generate
    for (gi = 0; gi < N_NODES; gi++) begin : g_pack
      assign nodes_d[gi*DW +: DW] = node[gi];
    end
  endgenerate

  // Output registers: load every cycle, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nodes_q <= '0;
      final_q <= '0;
    end else begin
      nodes_q <= nodes_d;
      final_q <= final_d;
    end
  end

  assign y = nodes_q;
  assign Y = final_q;

endmodule

// File: tb/tb_mux7x1_using2x1_dut.sv
// Self-checking bench: a DW=1 and a DW=4 instance share clock, reset and
// select; expectations come from a lane-index model of the selection rules.
module tb_mux7x1_using2x1_dut;

  logic        clk;
  logic        rst;
  logic [2:0]  s;
  logic [6:0]  i1;
  logic [27:0] i4;
  logic [4:0]  y1;
  logic        Y1;
  logic [19:0] y4;
  logic [3:0]  Y4;

  int errors;
  int checks;

  // Expected outputs for the most recent edge (kept for hold checks).
  logic [4:0]  exp_y1;
  logic        exp_Y1;
  logic [19:0] exp_y4;
  logic [3:0]  exp_Y4;

  mux7x1_using2x1_dut #(.DW(1)) dut1 (
    .clk (clk), .rst (rst), .i (i1), .s (s), .y (y1), .Y (Y1)
  );

  mux7x1_using2x1_dut #(.DW(4)) dut4 (
    .clk (clk), .rst (rst), .i (i4), .s (s), .y (y4), .Y (Y4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane k of a packed input vector with lane width dw.
  function automatic logic [3:0] lane(input logic [27:0] iv, input int k, input int dw);
    logic [27:0] sh;
    sh = iv >> (k * dw);
    return sh[3:0] & ((4'd1 << dw) - 4'd1);
  endfunction

  // Which lane the mux delivers: codes 0..6 map directly, 7 aliases to 6.
  function automatic int sel_lane(input logic [2:0] sv);
    return (sv == 3'd7) ? 6 : int'(sv);
  endfunction

  // Node values from their selection meaning: each node is one input lane.
  function automatic logic [19:0] ref_nodes(input logic [27:0] iv, input logic [2:0] sv, input int dw);
    int lo;
    logic [19:0] r;
    lo = int'(sv[0]);
    r = '0;
    r = r | (20'(lane(iv, lo,     dw)) << (0 * dw));
    r = r | (20'(lane(iv, 2 + lo, dw)) << (1 * dw));
    r = r | (20'(lane(iv, 4 + lo, dw)) << (2 * dw));
    r = r | (20'(lane(iv, 2 * int'(sv[1]) + lo, dw)) << (3 * dw));
    r = r | (20'(lane(iv, sv[1] ? 6 : 4 + lo, dw)) << (4 * dw));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      $error("%s mismatch", tag);
    end
  endtask

  // One clock: drive at negedge, check both instances just after posedge.
  task automatic cycle(input logic r, input logic [6:0] a1, input logic [27:0] a4,
                       input logic [2:0] sv, input string tag);
    logic [19:0] n4;
    @(negedge clk);
    rst = r; i1 = a1; i4 = a4; s = sv;
    @(posedge clk);
    #1;
    if (r) begin
      exp_y1 = '0; exp_Y1 = 1'b0; exp_y4 = '0; exp_Y4 = '0;
    end else begin
      n4     = ref_nodes({21'd0, a1}, sv, 1);
      exp_y1 = n4[4:0];
      exp_Y1 = a1[sel_lane(sv)];
      exp_y4 = ref_nodes(a4, sv, 4);
      exp_Y4 = lane(a4, sel_lane(sv), 4);
    end
    chk({tag, ".y1"}, {15'd0, y1}, {15'd0, exp_y1});
    chk({tag, ".Y1"}, {19'd0, Y1}, {19'd0, exp_Y1});
    chk({tag, ".y4"}, y4, exp_y4);
    chk({tag, ".Y4"}, {16'd0, Y4}, {16'd0, exp_Y4});
  endtask

  localparam logic [6:0]  PAT1 = 7'b0110001;
  localparam logic [27:0] WALK = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; s = '0; i1 = '0; i4 = '0;

    // Reset with arbitrary inputs for two cycles.
    cycle(1'b1, 7'($urandom), 28'($urandom), 3'($urandom), "rst0");
    cycle(1'b1, 7'($urandom), 28'($urandom), 3'($urandom), "rst1");

    // Select sweep: DW=1 pattern and DW=4 walking lanes together.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, PAT1, WALK, 3'(k), $sformatf("sweep_s%0d", k));
      if (k == 0) chk("node_s0", {15'd0, y1}, 20'b11101);
      if (k == 7) chk("node_s7", {15'd0, y1}, 20'b00100);
      chk($sformatf("walk_Y_s%0d", k), {16'd0, Y4}, (k == 7) ? 20'd6 : 20'(k));
    end

    // Inputs changing between edges must not disturb registered outputs.
    @(negedge clk);
    s = 3'd4; i1 = ~PAT1; i4 = ~WALK;
    #2;
    chk("hold.Y1", {19'd0, Y1}, {19'd0, exp_Y1});
    chk("hold.y4", y4, exp_y4);

    // Reset pulse mid-sweep, then values resume.
    cycle(1'b0, PAT1, WALK, 3'd4, "mid_pre");
    cycle(1'b1, PAT1, WALK, 3'd5, "mid_rst");
    cycle(1'b0, PAT1, WALK, 3'd5, "mid_post");
    chk("mid_post_Y1", {19'd0, Y1}, 20'd1);

    // Aliasing of codes 6 and 7 onto lane 6.
    cycle(1'b0, 7'b1000000, 28'h5000000, 3'd6, "alias6");
    chk("alias6_Y1", {19'd0, Y1}, 20'd1);
    cycle(1'b0, 7'b1000000, 28'h5000000, 3'd7, "alias7");
    chk("alias7_Y1", {19'd0, Y1}, 20'd1);
    cycle(1'b0, 7'b0000000, 28'h0000000, 3'd7, "alias7_zero");

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 60; k++) begin
      cycle(($urandom_range(0, 15) == 0), 7'($urandom), 28'($urandom), 3'($urandom),
            $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
